io_bridge: RTL and testbench

Memory-mapped bus bridge between the CPU core's byte-wide memory port and the system RAM and UART. It decodes each CPU access as either RAM or I/O and holds TX and RX byte FIFOs. It also provides the running cycle counter and the program-stop flag, and generates the `io_buffer_full` back-pressure that the core consumes. It sits directly downstream of the CPU top inside the SoC top.

---
 rtl/io_bridge.sv | 173 +++++++++++++++++
 tb/tb_io_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
// io_bridge : CPU byte-bus bridge to RAM, UART TX/RX FIFOs and cycle counter.
// Optional RX FIFO enabled by macro IO_BRIDGE_RX_EN.            Rev 1.0
// ============================================================================
module io_bridge #(
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic        ram_wr,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_end
);
  localparam int                     c_tx_n      = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] c_tx_depth  = c_tx_n[TX_DEPTH_LOG2:0];
  localparam logic [TX_DEPTH_LOG2:0] c_margin    = FULL_MARGIN[TX_DEPTH_LOG2:0];
  localparam logic [17:0]            c_addr_data = 18'h30000;
  localparam logic [17:0]            c_addr_ctrl = 18'h30004;

  logic        w_io, w_io_acc, w_io_wr, w_io_rd;
  logic [17:0] w_addr;
  logic [7:0]  w_rx_rd_byte, w_io_byte;
  logic        w_unused;

  assign w_addr   = cpu_a[17:0];
  assign w_io     = (cpu_a[17:16] == 2'b11);
  assign w_io_acc = rdy_in & w_io;
  assign w_io_wr  = w_io_acc & cpu_wr;
  assign w_io_rd  = w_io_acc & ~cpu_wr;

  assign ram_a   = cpu_a[16:0];
  assign ram_din = cpu_dout;
  assign ram_wr  = rdy_in & cpu_wr & ~w_io;

  // TX FIFO
  logic [7:0]               tx_mem_q [c_tx_n];
  logic [TX_DEPTH_LOG2-1:0] tx_head_q, tx_tail_q;
  logic [TX_DEPTH_LOG2:0]   tx_count_q, tx_count_d, w_tx_free;
  logic                     w_tx_push, w_tx_pop, io_full_q;

  assign tx_valid       = (tx_count_q != '0);
  assign tx_data        = tx_mem_q[tx_head_q];
  assign w_tx_pop       = tx_valid & tx_ready;
  assign w_tx_push      = w_io_wr & (w_addr == c_addr_data) & (cpu_dout != 8'h00) &
                          (tx_count_q != c_tx_depth);
  assign w_tx_free      = c_tx_depth - tx_count_d;
  assign io_buffer_full = io_full_q;

  always_comb begin
    tx_count_d = tx_count_q;
    if (w_tx_push && !w_tx_pop)      tx_count_d = tx_count_q + 1'b1;
    else if (!w_tx_push && w_tx_pop) tx_count_d = tx_count_q - 1'b1;
  end

  // Flag is computed from the next count so it moves the cycle after the push/pop.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tx_head_q  <= '0;
      tx_tail_q  <= '0;
      tx_count_q <= '0;
      io_full_q  <= 1'b0;
    end else begin
      if (w_tx_push) tx_tail_q <= tx_tail_q + 1'b1;
      if (w_tx_pop)  tx_head_q <= tx_head_q + 1'b1;
      tx_count_q <= tx_count_d;
      io_full_q  <= (w_tx_free <= c_margin);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_tx_push) tx_mem_q[tx_tail_q] <= cpu_dout;
  end

`ifdef IO_BRIDGE_RX_EN
  localparam int                     c_rx_n     = 1 << RX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] c_rx_depth = c_rx_n[RX_DEPTH_LOG2:0];

  logic [7:0]               rx_mem_q [c_rx_n];
  logic [RX_DEPTH_LOG2-1:0] rx_head_q, rx_tail_q;
  logic [RX_DEPTH_LOG2:0]   rx_count_q, rx_count_d;
  logic                     w_rx_push, w_rx_pop, w_rx_empty;

  assign w_rx_empty   = (rx_count_q == '0);
  assign rx_ready     = (rx_count_q != c_rx_depth);
  assign w_rx_push    = rx_valid & rx_ready;
  assign w_rx_pop     = w_io_rd & (w_addr == c_addr_data) & ~w_rx_empty;
  assign w_rx_rd_byte = w_rx_empty ? 8'h00 : rx_mem_q[rx_head_q];
  assign w_unused     = &{1'b0, cpu_a[31:18]};

  always_comb begin
    rx_count_d = rx_count_q;
    if (w_rx_push && !w_rx_pop)      rx_count_d = rx_count_q + 1'b1;
    else if (!w_rx_push && w_rx_pop) rx_count_d = rx_count_q - 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_head_q  <= '0;
      rx_tail_q  <= '0;
      rx_count_q <= '0;
    end else begin
      if (w_rx_push) rx_tail_q <= rx_tail_q + 1'b1;
      if (w_rx_pop)  rx_head_q <= rx_head_q + 1'b1;
      rx_count_q <= rx_count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_rx_push) rx_mem_q[rx_tail_q] <= rx_data;
  end
`else
  localparam int c_rx_unused = RX_DEPTH_LOG2;

  assign rx_ready     = 1'b0;
  assign w_rx_rd_byte = 8'h00;
  assign w_unused     = &{1'b0, cpu_a[31:18], rx_data, rx_valid};
`endif

  logic [31:0] cnt_q;
  logic [31:8] snap_q;
  logic [7:0]  io_byte_q;
  logic        last_io_q, pend_q;

  always_comb begin
    w_io_byte = 8'h00;
    if (w_io_rd) begin
      if (w_addr == c_addr_data)                w_io_byte = w_rx_rd_byte;
      else if (w_addr == c_addr_ctrl)           w_io_byte = cnt_q[7:0];
      else if (w_addr == c_addr_ctrl + 18'd1)   w_io_byte = snap_q[15:8];
      else if (w_addr == c_addr_ctrl + 18'd2)   w_io_byte = snap_q[23:16];
      else if (w_addr == c_addr_ctrl + 18'd3)   w_io_byte = snap_q[31:24];
    end
  end

  // last_io_q resets to 1 so cpu_din shows the cleared I/O byte rather than RAM.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      snap_q    <= '0;
      io_byte_q <= 8'h00;
      last_io_q <= 1'b1;
      pend_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (rdy_in)                                last_io_q <= w_io;
      if (w_io_acc)                              io_byte_q <= w_io_byte;
      if (w_io_rd && (w_addr == c_addr_ctrl))    snap_q    <= cnt_q[31:8];
      if (w_io_wr && (w_addr == c_addr_ctrl))    pend_q    <= 1'b1;
    end
  end

  assign cpu_din     = last_io_q ? io_byte_q : ram_dout;
  assign program_end = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// ============================================================================
// tb_io_bridge : directed + random stimulus against a queue-based bridge model.
// Rev 1.0
// ============================================================================
module tb_io_bridge;
`ifdef IO_BRIDGE_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic        clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b0, cpu_wr = 1'b0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] cpu_a = '0;
  logic [7:0]  cpu_dout = '0, rx_data = '0, ram_dout = '0;
  logic [7:0]  cpu_din, ram_din, tx_data;
  logic [16:0] ram_a;
  logic        io_buffer_full, ram_wr, tx_valid, rx_ready, program_end;

  io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full), .ram_a(ram_a), .ram_wr(ram_wr),
    .ram_din(ram_din), .ram_dout(ram_dout), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .program_end(program_end)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM attached to the bridge
  bit [7:0] ram_mem [131072];
  always @(posedge clk_in) begin
    ram_dout <= ram_mem[ram_a];
    if (ram_wr) ram_mem[ram_a] <= ram_din;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit [7:0]    ram_model [131072];
  byte unsigned tx_q[$], rx_q[$], tx_seen_q[$];
  bit          m_pend, m_last_io;
  byte unsigned m_io_byte;
  int unsigned m_cnt, m_snap;

  task automatic do_reset();
    rdy_in = 1'b0; cpu_wr = 1'b0; cpu_a = '0; tx_ready = 1'b0; rx_valid = 1'b0;
    rst_in = 1'b1;
    #1;
    chk("async_tx_valid", tx_valid, 0);
    chk("async_pend", program_end, 0);
    chk("async_full", io_buffer_full, 0);
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_cpu_din", cpu_din, 0);
    chk("rst_full", io_buffer_full, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, RX_EN);
    chk("rst_pend", program_end, 0);
    chk("rst_ram_wr", ram_wr, 0);
    rst_in = 1'b0;
    tx_q.delete(); rx_q.delete();
    m_pend = 0; m_last_io = 1; m_io_byte = 0; m_cnt = 0; m_snap = 0;
  endtask

  task automatic step(input bit rdy, input logic [31:0] a, input byte unsigned d,
                      input bit wr, input bit txr, input byte unsigned rxd, input bit rxv);
    bit io, txpush, txpop, rxpush;
    logic [17:0] ad;
    byte unsigned rd, ram_old;
    logic [7:0] exp_din;
    rdy_in = rdy; cpu_a = a; cpu_dout = d; cpu_wr = wr;
    tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    #1;
    io = (a[17:16] == 2'b11);
    ad = a[17:0];
    chk("ram_wr", ram_wr, rdy && wr && !io);
    chk("ram_a", ram_a, a[16:0]);
    chk("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q[0]);
    chk("rx_ready", rx_ready, RX_EN && rx_q.size() < 16);
    if (tx_valid && txr) tx_seen_q.push_back(tx_data);

    txpop  = txr && tx_q.size() != 0;
    txpush = rdy && io && wr && ad == 18'h30000 && d != 0 && tx_q.size() < 16;
    rxpush = RX_EN && rxv && rx_q.size() < 16;
    rd = 0;
    if (rdy && io && !wr) begin
      if (ad == 18'h30000) begin
        if (RX_EN && rx_q.size() != 0) rd = rx_q.pop_front();
      end else if (ad == 18'h30004) begin
        rd = m_cnt[7:0];
        m_snap = m_cnt;
      end else if (ad >= 18'h30005 && ad <= 18'h30007) begin
        rd = 8'(m_snap >> (8 * int'(ad - 18'h30004)));
      end
    end
    if (rdy && io) m_io_byte = rd;
    if (rdy) m_last_io = io;
    ram_old = ram_model[a[16:0]];
    if (rdy && wr && !io) ram_model[a[16:0]] = d;
    exp_din = m_last_io ? m_io_byte : ram_old;
    if (txpop)  void'(tx_q.pop_front());
    if (txpush) tx_q.push_back(d);
    if (rxpush) rx_q.push_back(rxd);
    if (rdy && io && wr && ad == 18'h30004) m_pend = 1;

    @(posedge clk_in);
    #1;
    m_cnt++;
    chk("cpu_din", cpu_din, exp_din);
    chk("io_buffer_full", io_buffer_full, (16 - tx_q.size()) <= 2);
    chk("program_end", program_end, m_pend);
  endtask

  task automatic idle(input bit txr);
    step(1'b1, 32'h0, 8'h00, 1'b0, txr, 8'h00, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int sel;
    a   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1: a[17:0] = 18'h30000;
      2:    a[17:0] = 18'h30004;
      3:    a[17:0] = 18'h30005;
      4:    a[17:0] = 18'h30006;
      5:    a[17:0] = 18'h30007;
      6:    a[17:0] = 18'h30000 + 18'($urandom_range(8, 200));
      default: begin
        a[17:16] = 2'($urandom_range(0, 2));
        a[15:0]  = 16'($urandom_range(0, 63));
      end
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] snap;
    #3;
    do_reset();

    // Counter snapshot after 10 idle cycles
    repeat (10) idle(1'b0);
    step(1'b1, 32'h30004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); snap[7:0]   = cpu_din;
    step(1'b1, 32'h30005, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); snap[15:8]  = cpu_din;
    step(1'b1, 32'h30006, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); snap[23:16] = cpu_din;
    step(1'b1, 32'h30007, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0); snap[31:24] = cpu_din;
    chk("counter_snapshot", snap, 32'd10);

    // TX: zero byte is filtered out
    tx_seen_q.delete();
    step(1'b1, 32'h30000, 8'h41, 1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 32'h30000, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 32'h30000, 8'h42, 1'b1, 1'b1, 8'h00, 1'b0);
    repeat (3) idle(1'b1);
    chk("tx_seq_len", tx_seen_q.size(), 2);
    chk("tx_seq_0", tx_seen_q[0], 8'h41);
    chk("tx_seq_1", tx_seen_q[1], 8'h42);

    // TX fill to full, overflow drop, drain
    tx_seen_q.delete();
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 32'h30000, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
      if (i == 13) chk("full_after13", io_buffer_full, 0);
      if (i == 14) chk("full_after14", io_buffer_full, 1);
    end
    repeat (20) idle(1'b1);
    chk("drain_count", tx_seen_q.size(), 16);
    chk("drain_last", tx_seen_q[15], 8'd16);
    chk("full_drained", io_buffer_full, 0);

    // RAM write/read, then empty RX read
    step(1'b1, 32'h00010, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 32'h00010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("ram_readback", cpu_din, 8'h5A);
    step(1'b1, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rx_empty_read", cpu_din, 8'h00);

    // RX single byte then two reads
    step(1'b1, 32'h0, 8'h00, 1'b0, 1'b0, 8'h33, 1'b1);
    step(1'b1, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rx_read_1", cpu_din, RX_EN ? 8'h33 : 8'h00);
    step(1'b1, 32'h30000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rx_read_2", cpu_din, 8'h00);

    // program_end ignores writes while not ready, then sticks
    step(1'b0, 32'h30004, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("pend_rdy_low", program_end, 0);
    step(1'b1, 32'h30004, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("pend_set", program_end, 1);
    repeat (5) idle(1'b0);
    chk("pend_hold", program_end, 1);
    do_reset();

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset();
      step($urandom_range(0, 9) != 0, rand_addr(),
           ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
           8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
